// File: rtl/pc_unit.sv
// Fetch-stage program counter for the MIPS core: next-PC selection with stall
// and exception redirect, plus a circular return-address stack for jr $ra prediction.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180),
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exception,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             branch_taken,
  input  logic [15:0]      branch_imm,
  input  logic             link_push,
  input  logic             ret_pop,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_valid,
  output logic             ras_overflow,
  output logic             misaligned
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [PTR_W-1:0] top_inc, top_dec;
  logic             ras_en, ras_empty, ras_full;

  assign pc_plus4  = pc_q + WIDTH'(4);
  // Branch base is the delay-slot address, so imm = -1 lands back on pc_out.
  assign br_off    = {{(WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};
  assign br_target = pc_plus4 + br_off;
  assign j_target  = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};

  always_comb begin
    pc_d = pc_plus4;
    if (exception)         pc_d = EXC_VECTOR;
    else if (stall)        pc_d = pc_q;
    else if (jump_reg)     pc_d = reg_target;
    else if (jump)         pc_d = j_target;
    else if (branch_taken) pc_d = br_target;
  end

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_FULL);
  assign top_inc   = (top_q == PTR_LAST) ? '0 : top_q + PTR_W'(1);
  assign top_dec   = (top_q == '0) ? PTR_LAST : top_q - PTR_W'(1);
  assign ras_en    = !exception && !stall;

  // When full, top+1 is the oldest slot, so a plain push overwrites it.
  always_comb begin
    ras_mem_d = ras_mem_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    if (ras_en) begin
      if (link_push && (!ret_pop || ras_empty)) begin
        ras_mem_d[top_inc] = pc_plus4;
        top_d              = top_inc;
        if (ras_full) ovf_d = 1'b1;
        else          cnt_d = cnt_q + CNT_W'(1);
      end else if (link_push && ret_pop) begin
        ras_mem_d[top_q] = pc_plus4;
      end else if (ret_pop && !ras_empty) begin
        top_d = top_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      top_q     <= top_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      ras_mem_q <= ras_mem_d;
    end
  end

  assign pc_out       = pc_q;
  assign ras_valid    = !ras_empty;
  assign ras_top      = ras_empty ? '0 : ras_mem_q[top_q];
  assign ras_overflow = ovf_q;
  assign misaligned   = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: next-PC priority, wraparound and RAS behaviour.
module tb_pc_unit;
  logic        clk = 1'b0;
  logic        reset, stall, exception, jump_reg, jump, branch_taken, link_push, ret_pop;
  logic [31:0] reg_target;
  logic [25:0] jump_index;
  logic [15:0] branch_imm;
  logic [31:0] pc_out, pc_plus4, ras_top;
  logic        ras_valid, ras_overflow, misaligned;

  int total = 0;
  int bad   = 0;

  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h8000_0180), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .exception(exception),
    .jump_reg(jump_reg), .reg_target(reg_target), .jump(jump), .jump_index(jump_index),
    .branch_taken(branch_taken), .branch_imm(branch_imm),
    .link_push(link_push), .ret_pop(ret_pop),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .ras_top(ras_top), .ras_valid(ras_valid),
    .ras_overflow(ras_overflow), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic idle();
    reset = 0; stall = 0; exception = 0; jump_reg = 0; jump = 0;
    branch_taken = 0; link_push = 0; ret_pop = 0;
    reg_target = '0; jump_index = '0; branch_imm = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    jump_reg = 1; reg_target = a; tick(); jump_reg = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    do_reset();
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
    total++; if (ras_valid !== 1'b0 || ras_top !== 32'h0 || ras_overflow !== 1'b0) begin
      bad++; $display("FAIL reset_ras got v=%b top=%h ovf=%b exp v=0 top=0 ovf=0", ras_valid, ras_top, ras_overflow); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h exp=%h", pc_plus4, 32'h4); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = 32'(i * 4);
      total++; if (pc_out !== exp || misaligned !== 1'b0) begin
        bad++; $display("FAIL seq_%0d got=%h mis=%b exp=%h mis=0", i, pc_out, misaligned, exp); end
    end
  endtask

  task automatic test_branch();
    do_reset();
    goto_pc(32'h100);
    branch_taken = 1; branch_imm = 16'hFFFC; tick(); branch_taken = 0;
    total++; if (pc_out !== 32'h0000_00F4) begin bad++; $display("FAIL branch_neg got=%h exp=%h", pc_out, 32'h0000_00F4); end
    goto_pc(32'h100);
    branch_taken = 1; branch_imm = 16'h0010; tick();
    total++; if (pc_out !== 32'h0000_0144) begin bad++; $display("FAIL branch_pos got=%h exp=%h", pc_out, 32'h0000_0144); end
    branch_imm = 16'hFFFF; tick(); branch_taken = 0;
    total++; if (pc_out !== 32'h0000_0144) begin bad++; $display("FAIL branch_self got=%h exp=%h", pc_out, 32'h0000_0144); end
  endtask

  task automatic test_jump();
    do_reset();
    goto_pc(32'h4000_0010);
    jump = 1; jump_index = 26'h0000040; tick(); jump = 0;
    total++; if (pc_out !== 32'h4000_0100) begin bad++; $display("FAIL jump got=%h exp=%h", pc_out, 32'h4000_0100); end
    goto_pc(32'h4000_0010);
    jump = 1; jump_index = 26'h0000040; jump_reg = 1; reg_target = 32'h0000_2002; tick();
    jump = 0; jump_reg = 0;
    total++; if (pc_out !== 32'h0000_2002) begin bad++; $display("FAIL jr_prio got=%h exp=%h", pc_out, 32'h0000_2002); end
    total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL misaligned got=%b exp=1", misaligned); end
    total++; if (pc_plus4 !== 32'h0000_2006) begin bad++; $display("FAIL mis_pc4 got=%h exp=%h", pc_plus4, 32'h0000_2006); end
  endtask

  task automatic test_stall_exception();
    do_reset();
    link_push = 1; jump_reg = 1; reg_target = 32'h200; tick();  // pushes 0x4
    link_push = 0; jump_reg = 0;
    total++; if (pc_out !== 32'h200 || ras_top !== 32'h4 || ras_valid !== 1'b1) begin
      bad++; $display("FAIL stall_setup got pc=%h top=%h v=%b exp pc=200 top=4 v=1", pc_out, ras_top, ras_valid); end
    stall = 1; branch_taken = 1; branch_imm = 16'h0040; link_push = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc_out !== 32'h200 || ras_top !== 32'h4) begin
        bad++; $display("FAIL stall_%0d got pc=%h top=%h exp pc=200 top=4", i, pc_out, ras_top); end
    end
    exception = 1; tick();
    total++; if (pc_out !== 32'h8000_0180) begin bad++; $display("FAIL exc got=%h exp=%h", pc_out, 32'h8000_0180); end
    total++; if (ras_top !== 32'h4 || ras_valid !== 1'b1 || ras_overflow !== 1'b0) begin
      bad++; $display("FAIL exc_ras got top=%h v=%b ovf=%b exp top=4 v=1 ovf=0", ras_top, ras_valid, ras_overflow); end
    idle();
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_top [4];
    exp_top[0] = 32'h44; exp_top[1] = 32'h34; exp_top[2] = 32'h24; exp_top[3] = 32'h0;
    do_reset();
    goto_pc(32'h10);
    for (int i = 1; i <= 5; i++) begin
      link_push = 1; jump_reg = 1; reg_target = 32'((i + 1) * 16); tick();
    end
    link_push = 0; jump_reg = 0;
    total++; if (ras_overflow !== 1'b1 || ras_top !== 32'h54) begin
      bad++; $display("FAIL ras_full got ovf=%b top=%h exp ovf=1 top=54", ras_overflow, ras_top); end
    ret_pop = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (ras_top !== exp_top[i] || ras_valid !== (i < 3)) begin
        bad++; $display("FAIL pop_%0d got top=%h v=%b exp top=%h v=%b", i, ras_top, ras_valid, exp_top[i], (i < 3)); end
    end
    tick(); ret_pop = 0;
    total++; if (ras_valid !== 1'b0 || ras_top !== 32'h0 || ras_overflow !== 1'b1) begin
      bad++; $display("FAIL pop_empty got v=%b top=%h ovf=%b exp v=0 top=0 ovf=1", ras_valid, ras_top, ras_overflow); end
  endtask

  task automatic test_push_pop();
    do_reset();
    link_push = 1; ret_pop = 1; tick();  // empty: acts as push of 0x4
    total++; if (ras_valid !== 1'b1 || ras_top !== 32'h4) begin
      bad++; $display("FAIL pp_empty got v=%b top=%h exp v=1 top=4", ras_valid, ras_top); end
    tick();  // at pc 4: replace top with 0x8
    link_push = 0;
    total++; if (ras_top !== 32'h8) begin bad++; $display("FAIL pp_replace got=%h exp=%h", ras_top, 32'h8); end
    tick(); ret_pop = 0;
    total++; if (ras_valid !== 1'b0 || ras_top !== 32'h0) begin
      bad++; $display("FAIL pp_count got v=%b top=%h exp v=0 top=0", ras_valid, ras_top); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    goto_pc(32'hFFFF_FFFC);
    tick();
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL wrap got=%h exp=%h", pc_out, 32'h0); end
    link_push = 1;
    for (int i = 0; i < 5; i++) tick();
    total++; if (ras_overflow !== 1'b1 || ras_valid !== 1'b1 || pc_out !== 32'h14) begin
      bad++; $display("FAIL prefill got ovf=%b v=%b pc=%h exp ovf=1 v=1 pc=14", ras_overflow, ras_valid, pc_out); end
    stall = 1; tick();
    reset = 1; tick(); reset = 0; stall = 0; link_push = 0;
    total++; if (pc_out !== 32'h0 || ras_valid !== 1'b0 || ras_overflow !== 1'b0 || ras_top !== 32'h0) begin
      bad++; $display("FAIL reset_mid got pc=%h v=%b ovf=%b top=%h exp pc=0 v=0 ovf=0 top=0",
                      pc_out, ras_valid, ras_overflow, ras_top); end
  endtask

  initial begin
    idle();
    test_reset();
    test_branch();
    test_jump();
    test_stall_exception();
    test_ras_overflow();
    test_push_pop();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parameterised program-counter unit for the MIPS core fetch stage.
- Holds the architectural PC and selects the next PC from these sources: sequential PC+4, branch offset, jump index, register target, or exception vector.
- Supports fetch stall.
- Includes a small return-address stack (RAS). Fetch uses it to predict jr $ra targets.

Parameters:
WIDTH, 32, PC/address width; must be >= 32
RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
EXC_VECTOR, 32'h8000_0180, PC value loaded on exception
RAS_DEPTH, 4, return-address stack entries (>= 2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and RAS this cycle
exception  input  1  redirect to EXC_VECTOR
jump_reg  input  1  take reg_target (jr/jalr)
reg_target  input  WIDTH  register-sourced target
jump  input  1  take jump target (j/jal)
jump_index  input  26  instr[25:0]
branch_taken  input  1  take branch target
branch_imm  input  16  instr[15:0] offset
link_push  input  1  push pc_plus4 onto RAS (jal/jalr)
ret_pop  input  1  pop RAS (jr $ra)
pc_out  output  WIDTH  current PC (registered)
pc_plus4  output  WIDTH  pc_out + 4 (combinational)
ras_top  output  WIDTH  top RAS entry; 0 when empty
ras_valid  output  1  RAS non-empty
ras_overflow  output  1  sticky: a push occurred while full
misaligned  output  1  pc_out[1:0] != 0 (combinational)

Behaviour:
- Reset: synchronous, active-high; dominates all other inputs on the same edge. pc_out <= RESET_VECTOR. RAS count <= 0. ras_top = 0, ras_valid = 0, ras_overflow <= 0.
- Next-PC priority per rising edge, highest first:
  1. reset
  2. exception -> EXC_VECTOR
  3. stall -> hold pc_out
  4. jump_reg -> reg_target
  5. jump -> {pc_plus4[WIDTH-1:28], jump_index, 2'b00}
  6. branch_taken -> pc_plus4 + (sign_extend(branch_imm) << 2)
  7. otherwise pc_plus4
- Latency: the selected target appears on pc_out one cycle after the inputs are sampled. There is no bubble inserted.
- Arithmetic: all adds are modulo 2^WIDTH, and carry-out is discarded. PC 32'hFFFF_FFFC sequential -> 32'h0000_0000. Negative offsets wrap the same way.
- Branch target base is pc_plus4, not pc_out, per MIPS delay-slot semantics. For branch_imm = 16'hFFFF the target is pc_out.
- No alignment correction. jump_reg with reg_target[1:0] != 0 loads the value as-is, and misaligned asserts while pc_out holds it.
- RAS is a circular LIFO with RAS_DEPTH entries, a top pointer and a count (0..RAS_DEPTH).
- RAS updates only on edges where reset = 0, exception = 0 and stall = 0. Otherwise RAS state is unchanged.
- Push only: writes pc_plus4 (the link address) at top+1, count += 1.
  - When full: the oldest entry is overwritten, count stays RAS_DEPTH, ras_overflow <= 1.
  - ras_overflow stays set until reset.
- Pop only: count -= 1.
  - When empty: no-op, no error flag.
- Push and pop together: the top entry is replaced by pc_plus4 and count is unchanged. When empty, this behaves as push.
- ras_top / ras_valid reflect registered state after the edge.
- RAS does not steer the PC internally; fetch uses ras_top externally and drives jump_reg/reg_target.
- Exception does not clear the RAS.

Test Plan:
1. Reset then 3 free-running cycles -> pc_out 0, 4, 8, 12. ras_valid = 0, misaligned = 0.
2. At pc_out = 32'h0000_0100, branch_taken = 1, branch_imm = 16'hFFFC -> next pc_out 32'h0000_00F4. branch_imm = 16'h0010 instead -> 32'h0000_0144.
3. At pc_out = 32'h4000_0010:
   - jump = 1, jump_index = 26'h0000040 -> 32'h4000_0100.
   - Same cycle with jump_reg = 1, reg_target = 32'h0000_2002 -> 32'h0000_2002 wins, misaligned = 1.
4. stall = 1 for 3 cycles with branch_taken and link_push asserted -> pc_out and RAS unchanged. Same cycle with exception = 1 -> pc_out = 32'h8000_0180.
5. RAS_DEPTH = 4: five link_push at pc_out = 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_overflow = 1 and ras_top = 0x54. Four pops yield ras_top 0x44, 0x34, 0x24, then empty (ras_valid = 0, ras_top = 0). A fifth pop is a no-op.
6. Sequential from 32'hFFFF_FFFC -> 32'h0000_0000. Reset asserted mid-stall with RAS full -> next edge pc_out = RESET_VECTOR, ras_valid = 0, ras_overflow = 0.
